// File: rtl/tmds_decoder_if.sv
// -----------------------------------------------------------------------------
// tmds_decoder_if
// Bundles the channel-side word input and the decoded outputs of one TMDS
// channel decoder.
//   TMDS_in    [9:0]  deserialized channel word, bit 0 first on the wire
//   bitslip           one-cycle request to shift the deserializer boundary
//   aligned           high while word lock is held
//   VD         [7:0]  decoded video data
//   CD         [1:0]  decoded control bits (C1,C0)
//   VDE               data-enable: current symbol is data and aligned
//   slip_count [15:0] number of bitslip pulses issued (0 unless stats enabled)
// Modports: master = the side that feeds words and consumes results,
//           slave  = the decoder itself.
// -----------------------------------------------------------------------------
interface tmds_decoder_if;
  logic [9:0]  TMDS_in;
  logic        bitslip;
  logic        aligned;
  logic [7:0]  VD;
  logic [1:0]  CD;
  logic        VDE;
  logic [15:0] slip_count;

  modport master (
    output TMDS_in,
    input  bitslip, aligned, VD, CD, VDE, slip_count
  );

  modport slave (
    input  TMDS_in,
    output bitslip, aligned, VD, CD, VDE, slip_count
  );
endinterface

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
// Decodes one TMDS channel (8b/10b video data and the four control tokens) and
// finds the 10-bit word boundary by hunting for a run of control tokens,
// requesting a deserializer bitslip whenever a search window expires.
//
// Ports:
//   pixclk  pixel clock, the only clock
//   rst     asynchronous active-high reset
//   bus     tmds_decoder_if.slave (TMDS_in in; bitslip, aligned, VD, CD, VDE,
//           slip_count out)
//
// Parameters:
//   CTRL_RUN    consecutive control tokens needed to declare lock
//   SEARCH_LEN  cycles spent searching before a bitslip is requested
//   SLIP_WAIT   settle cycles after a bitslip before searching resumes
//   LOSS_LEN    cycles in lock without a control token before lock is dropped
//
// Optional feature: define TMDS_DEC_STATS_EN to build a saturating counter of
// bitslip pulses on slip_count; otherwise slip_count is tied to zero.
// -----------------------------------------------------------------------------
module tmds_decoder #(
  parameter int CTRL_RUN   = 16,
  parameter int SEARCH_LEN = 2048,
  parameter int SLIP_WAIT  = 8,
  parameter int LOSS_LEN   = 2048
) (
  input  logic          pixclk,
  input  logic          rst,
  tmds_decoder_if.slave bus
);

  // One timer is shared by SEARCH, WAIT and LOCKED since each clears it on
  // entry; size it for the longest of the three windows.
  localparam int MAX_AB  = (SEARCH_LEN > LOSS_LEN) ? SEARCH_LEN : LOSS_LEN;
  localparam int MAX_LEN = (MAX_AB > SLIP_WAIT) ? MAX_AB : SLIP_WAIT;
  localparam int TIMER_W = $clog2(MAX_LEN + 1);
  localparam int RUN_W   = $clog2(CTRL_RUN + 1);

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

  state_t             state_reg;
  logic [RUN_W-1:0]   run_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               bitslip_reg;
  logic               aligned_reg;
  logic [7:0]         vd_reg;
  logic [1:0]         cd_reg;
  logic               vde_reg;

  // ---------------------------------------------------------------- decode --
  logic [7:0] q;
  logic [7:0] data_vd;
  logic       ctrl_hit;
  logic [1:0] ctrl_cd;

  // Undo the optional inversion, then undo the XOR/XNOR chain selected by bit 8.
  assign q          = bus.TMDS_in[7:0] ^ {8{bus.TMDS_in[9]}};
  assign data_vd[0] = q[0];

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_vd
      assign data_vd[gi] = bus.TMDS_in[8] ? (q[gi] ^ q[gi-1])
                                          : ~(q[gi] ^ q[gi-1]);
    end
  endgenerate

  always_comb begin
    ctrl_hit = 1'b1;
    ctrl_cd  = 2'b00;
    case (bus.TMDS_in)
      10'b1101010100: ctrl_cd = 2'b00;
      10'b0010101011: ctrl_cd = 2'b01;
      10'b0101010100: ctrl_cd = 2'b10;
      10'b1010101011: ctrl_cd = 2'b11;
      default:        ctrl_hit = 1'b0;
    endcase
  end

  // ----------------------------------------------------------- lock search --
  logic [RUN_W-1:0] run_inc;
  logic             lock_now;
  logic             enter_slip;

  // Saturating run of control tokens as it will be after this word.
  always_comb begin
    if (!ctrl_hit)
      run_inc = '0;
    else if (run_reg == RUN_W'(CTRL_RUN))
      run_inc = run_reg;
    else
      run_inc = run_reg + 1'b1;
  end

  assign lock_now   = (run_inc == RUN_W'(CTRL_RUN));
  // Lock takes priority over an expiring search window on the same cycle.
  assign enter_slip = (state_reg == SEARCH) && !lock_now &&
                      (timer_reg == TIMER_W'(SEARCH_LEN - 1));

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      state_reg   <= SEARCH;
      run_reg     <= '0;
      timer_reg   <= '0;
      bitslip_reg <= 1'b0;
      aligned_reg <= 1'b0;
    end else begin
      bitslip_reg <= 1'b0;
      case (state_reg)
        SEARCH: begin
          run_reg <= run_inc;
          if (lock_now) begin
            state_reg   <= LOCKED;
            aligned_reg <= 1'b1;
            timer_reg   <= '0;
            run_reg     <= '0;
          end else if (enter_slip) begin
            state_reg   <= SLIP;
            bitslip_reg <= 1'b1;
            timer_reg   <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        SLIP: begin
          // Always leaves after one cycle, so bitslip can never repeat back to back.
          state_reg <= WAIT;
          timer_reg <= '0;
        end
        WAIT: begin
          if (timer_reg == TIMER_W'(SLIP_WAIT - 1)) begin
            state_reg <= SEARCH;
            timer_reg <= '0;
            run_reg   <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        LOCKED: begin
          if (ctrl_hit) begin
            timer_reg <= '0;
          end else if (timer_reg == TIMER_W'(LOSS_LEN - 1)) begin
            state_reg   <= SEARCH;
            aligned_reg <= 1'b0;
            timer_reg   <= '0;
            run_reg     <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= SEARCH;
          aligned_reg <= 1'b0;
          timer_reg   <= '0;
          run_reg     <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------- output register --
  // VDE follows the lock state seen alongside the word, not the next one.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      vd_reg  <= '0;
      cd_reg  <= '0;
      vde_reg <= 1'b0;
    end else if (ctrl_hit) begin
      cd_reg  <= ctrl_cd;
      vde_reg <= 1'b0;
    end else begin
      vd_reg  <= data_vd;
      vde_reg <= aligned_reg;
    end
  end

  assign bus.bitslip = bitslip_reg;
  assign bus.aligned = aligned_reg;
  assign bus.VD      = vd_reg;
  assign bus.CD      = cd_reg;
  assign bus.VDE     = vde_reg;

  // ------------------------------------------------------------ statistics --
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] slip_count_reg;

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst)
      slip_count_reg <= '0;
    else if (enter_slip && (slip_count_reg != 16'hFFFF))
      slip_count_reg <= slip_count_reg + 16'd1;
  end

  assign bus.slip_count = slip_count_reg;
`else
  assign bus.slip_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
// Directed bench for tmds_decoder: a behavioural model predicts every output on
// every cycle (checked on the falling edge), and literal expectations pin the
// key vectors: lock after 16 tokens, A5 decode, the four control tokens,
// lock loss, 3-bit rotation recovery, async reset in WAIT, slip statistics.
// -----------------------------------------------------------------------------
module tb_tmds_decoder;
  localparam int CTRL_RUN   = 16;
  localparam int SEARCH_LEN = 2048;
  localparam int SLIP_WAIT  = 8;
  localparam int LOSS_LEN   = 2048;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  localparam int P_SEARCH = 0, P_SLIP = 1, P_WAIT = 2, P_LOCKED = 3;

  logic pixclk = 1'b0;
  logic rst    = 1'b1;

  tmds_decoder_if bus ();

  tmds_decoder #(
    .CTRL_RUN  (CTRL_RUN),
    .SEARCH_LEN(SEARCH_LEN),
    .SLIP_WAIT (SLIP_WAIT),
    .LOSS_LEN  (LOSS_LEN)
  ) dut (
    .pixclk(pixclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 pixclk = ~pixclk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // ------------------------------------------------------------------ model --
  int         m_phase, m_run, m_cnt, m_slips;
  logic [7:0] m_vd;
  logic [1:0] m_cd;
  logic       m_vde, m_aligned, m_bitslip;

  function automatic int token_index(input logic [9:0] w);
    logic [9:0] toks [4];
    toks = '{T0, T1, T2, T3};
    for (int i = 0; i < 4; i++)
      if (w == toks[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_decode(input logic [9:0] w);
    logic [7:0] q, d;
    q    = w[7:0] ^ {8{w[9]}};
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = (q[i] == q[i-1]) ^ w[8];
    return d;
  endfunction

  // Encoder with explicit mode/inversion; flips inversion if it hits a token.
  function automatic logic [9:0] enc(input logic [7:0] d, input bit xm, input bit inv);
    logic [7:0] qm;
    logic [9:0] w;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xm ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    w = {inv, xm, (inv ? ~qm : qm)};
    if (token_index(w) >= 0) w = {~inv, xm, (inv ? qm : ~qm)};
    return w;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] dd;
    dd = {w, w} >> k;
    return dd[9:0];
  endfunction

  function automatic logic [15:0] exp_slip_count();
`ifdef TMDS_DEC_STATS_EN
    return (m_slips > 65535) ? 16'hFFFF : 16'(m_slips);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    m_phase = P_SEARCH; m_run = 0; m_cnt = 0; m_slips = 0;
    m_vd = '0; m_cd = '0; m_vde = 1'b0; m_aligned = 1'b0; m_bitslip = 1'b0;
  endtask

  // Advance the model by one pixclk edge given the word presented before it.
  task automatic model_step(input logic [9:0] w);
    int tok;
    if (rst) begin
      model_reset();
      return;
    end
    tok = token_index(w);
    if (tok >= 0) begin
      m_cd  = tok[1:0];
      m_vde = 1'b0;
    end else begin
      m_vd  = model_decode(w);
      m_vde = (m_phase == P_LOCKED);
    end
    case (m_phase)
      P_SEARCH: begin
        m_run = (tok >= 0) ? ((m_run < CTRL_RUN) ? m_run + 1 : m_run) : 0;
        if (m_run >= CTRL_RUN) begin m_phase = P_LOCKED; m_cnt = 0; m_run = 0; end
        else if (m_cnt == SEARCH_LEN - 1) begin m_phase = P_SLIP; m_cnt = 0; end
        else m_cnt++;
      end
      P_SLIP: begin m_phase = P_WAIT; m_cnt = 0; end
      P_WAIT: begin
        if (m_cnt == SLIP_WAIT - 1) begin m_phase = P_SEARCH; m_cnt = 0; m_run = 0; end
        else m_cnt++;
      end
      default: begin
        if (tok >= 0) m_cnt = 0;
        else if (m_cnt == LOSS_LEN - 1) begin m_phase = P_SEARCH; m_cnt = 0; m_run = 0; end
        else m_cnt++;
      end
    endcase
    m_bitslip = (m_phase == P_SLIP);
    m_aligned = (m_phase == P_LOCKED);
    if (m_bitslip) m_slips++;
  endtask

  // ----------------------------------------------------------------- checks --
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic vec_check(input string name, input logic [15:0] act, input logic [15:0] exp);
    check(name, act, exp);
    if (act === exp) $display("vec %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge pixclk) begin
    if (chk_en) begin
      check("bitslip",    16'(bus.bitslip), 16'(m_bitslip));
      check("aligned",    16'(bus.aligned), 16'(m_aligned));
      check("VD",         16'(bus.VD),      16'(m_vd));
      check("CD",         16'(bus.CD),      16'(m_cd));
      check("VDE",        16'(bus.VDE),     16'(m_vde));
      check("slip_count", bus.slip_count,   exp_slip_count());
    end
  end

  // -------------------------------------------------------------- stimulus --
  task automatic step(input logic [9:0] w);
    bus.TMDS_in = w;
    @(posedge pixclk);
    model_step(w);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step(10'd0);
    step(10'd0);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    vec_check({tag, "_bitslip"},    16'(bus.bitslip), 16'h0);
    vec_check({tag, "_aligned"},    16'(bus.aligned), 16'h0);
    vec_check({tag, "_VD"},         16'(bus.VD),      16'h0);
    vec_check({tag, "_CD"},         16'(bus.CD),      16'h0);
    vec_check({tag, "_VDE"},        16'(bus.VDE),     16'h0);
    vec_check({tag, "_slip_count"}, bus.slip_count,   16'h0);
  endtask

  initial begin
    int pulses, off, n;
    bus.TMDS_in = '0;
    model_reset();
    chk_en = 1'b1;

    // Reset state.
    step(10'd0);
    step(10'd0);
    check_all_zero("reset");
    rst = 1'b0;

    // Lock on 20 tokens, then an encoded A5.
    for (int i = 1; i <= 20; i++) begin
      step(T0);
      if (i == 15) vec_check("pre_lock_aligned", 16'(bus.aligned), 16'h0);
      if (i == 16) vec_check("lock_aligned",     16'(bus.aligned), 16'h1);
    end
    step(10'h163);
    vec_check("a5_VD",  16'(bus.VD),  16'hA5);
    vec_check("a5_VDE", 16'(bus.VDE), 16'h1);

    // Each control token updates CD only.
    step(T1); vec_check("t1_CD", 16'(bus.CD), 16'h1); vec_check("t1_VDE", 16'(bus.VDE), 16'h0);
    vec_check("t1_VD", 16'(bus.VD), 16'hA5);
    step(T2); vec_check("t2_CD", 16'(bus.CD), 16'h2); vec_check("t2_VD", 16'(bus.VD), 16'hA5);
    step(T0); vec_check("t0_CD", 16'(bus.CD), 16'h0); vec_check("t0_VD", 16'(bus.VD), 16'hA5);
    step(T3); vec_check("t3_CD", 16'(bus.CD), 16'h3); vec_check("t3_VDE", 16'(bus.VDE), 16'h0);
    // Data words hold CD.
    step(10'h0AA); vec_check("x00_VD", 16'(bus.VD), 16'h00); vec_check("x00_CD", 16'(bus.CD), 16'h3);
    step(10'h3AA); vec_check("xff_VD", 16'(bus.VD), 16'hFF); vec_check("xff_VDE", 16'(bus.VDE), 16'h1);

    // Lock loss after LOSS_LEN data words.
    step(T0);
    for (int j = 1; j <= LOSS_LEN; j++) begin
      step(enc(8'(j), j[0], j[1]));
      if (j == LOSS_LEN - 1) vec_check("loss_hold_aligned", 16'(bus.aligned), 16'h1);
      if (j == LOSS_LEN)     vec_check("loss_drop_aligned", 16'(bus.aligned), 16'h0);
    end
    for (int i = 0; i < CTRL_RUN; i++) step(T2);
    vec_check("relock_aligned", 16'(bus.aligned), 16'h1);

    // Stream rotated by 3 bits; each bitslip rotates back by one.
    do_reset();
    off = 3; pulses = 0; n = 0;
    while (!bus.aligned && n < 4 * (SEARCH_LEN + SLIP_WAIT + 1) + 40) begin
      step(rot(T0, off));
      n++;
      if (bus.bitslip) begin
        pulses++;
        if (off > 0) off--;
      end
    end
    vec_check("rot_pulses",  16'(pulses),      16'd3);
    vec_check("rot_aligned", 16'(bus.aligned), 16'h1);

    // Async reset during WAIT, then full search window before next slip.
    do_reset();
    n = 0;
    while (!bus.bitslip && n < SEARCH_LEN + 20) begin step(10'h136); n++; end
    vec_check("wait_pre_bitslip", 16'(bus.bitslip), 16'h1);
    step(10'h136); step(10'h136); step(10'h136);
    vec_check("wait_pre_VD", 16'(bus.VD), 16'h5A);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_rst");
    step(10'h136);
    rst = 1'b0;
    n = 0;
    while (!bus.bitslip && n < SEARCH_LEN + 100) begin step(10'h136); n++; end
    vec_check("post_rst_slip_delay", 16'(n), 16'(SEARCH_LEN));

    // Five slips for the statistics counter.
    do_reset();
    pulses = 0; n = 0;
    while (pulses < 5 && n < 5 * (SEARCH_LEN + SLIP_WAIT + 1) + 50) begin
      step(10'h136);
      n++;
      if (bus.bitslip) pulses++;
    end
`ifdef TMDS_DEC_STATS_EN
    vec_check("stats_slip_count", bus.slip_count, 16'd5);
`else
    vec_check("stats_slip_count", bus.slip_count, 16'd0);
`endif
    step(10'h136);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
